// File: rtl/lcd_pkg.sv
// Shared definitions for the 4-bit LCD write link (receiver side and io_bridge).
package lcd_pkg;

   typedef enum logic [1:0] {
      ST_SYNC8 = 2'd0,
      ST_HI    = 2'd1,
      ST_LO    = 2'd2
   } lcd_state_e;

   // Init nibble that switches the controller into 4-bit mode.
   localparam logic [3:0] LCD_INIT_4BIT = 4'h2;

   // Register-select encodings.
   localparam logic RS_CMD  = 1'b0;
   localparam logic RS_DATA = 1'b1;

endpackage

// File: rtl/lcd_strobe_qual.sv
// Input registers, lcd_e fall detection and strobe width qualification.
// Emits a one-cycle qualified-fall pulse with the nibble/rs/rw captured
// while lcd_e was still high, or a short_err pulse for a too-narrow strobe.
module lcd_strobe_qual
   import lcd_pkg::*;
#(
   parameter int unsigned MIN_E_HIGH = 12,
   parameter int unsigned CNT_W      = 12
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic       lcd_e,
   input  logic [3:0] lcd_d,
   output logic       fall_valid,
   output logic       fall_rs,
   output logic       fall_rw,
   output logic [3:0] fall_nibble,
   output logic       short_err
);

   logic             s1_e_q, s1_e_d;
   logic             s1_rs_q, s1_rs_d;
   logic             s1_rw_q, s1_rw_d;
   logic [3:0]       s1_d_q, s1_d_d;
   logic             s2_e_q, s2_e_d;
   logic             s2_rs_q, s2_rs_d;
   logic             s2_rw_q, s2_rw_d;
   logic [3:0]       s2_d_q, s2_d_d;
   logic [CNT_W-1:0] wcnt_q, wcnt_d;
   logic             fall_valid_q, fall_valid_d;
   logic             fall_rs_q, fall_rs_d;
   logic             fall_rw_q, fall_rw_d;
   logic [3:0]       fall_nibble_q, fall_nibble_d;
   logic             short_err_q, short_err_d;
   logic             fall;
   logic             wide_enough;

   // Pipeline shift, saturating width count and fall qualification.
   always_comb begin
      s1_e_d        = lcd_e;
      s1_rs_d       = lcd_rs;
      s1_rw_d       = lcd_rw;
      s1_d_d        = lcd_d;
      s2_e_d        = s1_e_q;
      s2_rs_d       = s1_rs_q;
      s2_rw_d       = s1_rw_q;
      s2_d_d        = s1_d_q;
      fall_rs_d     = fall_rs_q;
      fall_rw_d     = fall_rw_q;
      fall_nibble_d = fall_nibble_q;

      if (!s1_e_q) begin
         wcnt_d = '0;
      end else if (wcnt_q == '1) begin
         wcnt_d = wcnt_q;
      end else begin
         wcnt_d = wcnt_q + 1'b1;
      end

      // wcnt_q still holds the high width in the cycle the fall is seen.
      fall         = s2_e_q & ~s1_e_q;
      wide_enough  = (wcnt_q >= CNT_W'(MIN_E_HIGH));
      fall_valid_d = fall & wide_enough;
      short_err_d  = fall & ~wide_enough;

      if (fall) begin
         fall_rs_d     = s2_rs_q;
         fall_rw_d     = s2_rw_q;
         fall_nibble_d = s2_d_q;
      end
   end

   // State registers with synchronous reset; pipeline clears to e=0.
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_e_q        <= 1'b0;
         s1_rs_q       <= RS_CMD;
         s1_rw_q       <= 1'b0;
         s1_d_q        <= '0;
         s2_e_q        <= 1'b0;
         s2_rs_q       <= RS_CMD;
         s2_rw_q       <= 1'b0;
         s2_d_q        <= '0;
         wcnt_q        <= '0;
         fall_valid_q  <= 1'b0;
         fall_rs_q     <= RS_CMD;
         fall_rw_q     <= 1'b0;
         fall_nibble_q <= '0;
         short_err_q   <= 1'b0;
      end else begin
         s1_e_q        <= s1_e_d;
         s1_rs_q       <= s1_rs_d;
         s1_rw_q       <= s1_rw_d;
         s1_d_q        <= s1_d_d;
         s2_e_q        <= s2_e_d;
         s2_rs_q       <= s2_rs_d;
         s2_rw_q       <= s2_rw_d;
         s2_d_q        <= s2_d_d;
         wcnt_q        <= wcnt_d;
         fall_valid_q  <= fall_valid_d;
         fall_rs_q     <= fall_rs_d;
         fall_rw_q     <= fall_rw_d;
         fall_nibble_q <= fall_nibble_d;
         short_err_q   <= short_err_d;
      end
   end

   assign fall_valid  = fall_valid_q;
   assign fall_rs     = fall_rs_q;
   assign fall_rw     = fall_rw_q;
   assign fall_nibble = fall_nibble_q;
   assign short_err   = short_err_q;

endmodule

// File: rtl/lcd_nibble_rx.sv
// Receiver for the 4-bit HD44780-style write link: tracks the 8-bit init
// nibbles, then pairs high/low nibbles into bytes with their RS flag.
module lcd_nibble_rx
   import lcd_pkg::*;
#(
   parameter int unsigned MIN_E_HIGH     = 12,
   parameter int unsigned NIBBLE_TIMEOUT = 2000,
   parameter int unsigned CNT_W          = 12
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       lcd_rs,
   input  logic       lcd_rw,
   input  logic       lcd_e,
   input  logic [3:0] lcd_d,
   output logic       byte_valid,
   output logic [7:0] byte_data,
   output logic       byte_rs,
   output logic       init_valid,
   output logic [3:0] init_nibble,
   output logic       synced,
   output logic       short_err,
   output logic       frame_err
);

   logic       q_valid;
   logic       q_rs;
   logic       q_rw;
   logic [3:0] q_nib;
   logic       q_short;

   lcd_strobe_qual #(
      .MIN_E_HIGH (MIN_E_HIGH),
      .CNT_W      (CNT_W)
   ) u_qual (
      .clk         (clk),
      .rst         (rst),
      .lcd_rs      (lcd_rs),
      .lcd_rw      (lcd_rw),
      .lcd_e       (lcd_e),
      .lcd_d       (lcd_d),
      .fall_valid  (q_valid),
      .fall_rs     (q_rs),
      .fall_rw     (q_rw),
      .fall_nibble (q_nib),
      .short_err   (q_short)
   );

   lcd_state_e       state_q, state_d;
   logic [3:0]       hi_nib_q, hi_nib_d;
   logic             lrs_q, lrs_d;
   logic [CNT_W-1:0] tmo_q, tmo_d;
   logic             byte_valid_q, byte_valid_d;
   logic [7:0]       byte_data_q, byte_data_d;
   logic             byte_rs_q, byte_rs_d;
   logic             init_valid_q, init_valid_d;
   logic [3:0]       init_nibble_q, init_nibble_d;
   logic             synced_q, synced_d;
   logic             short_err_q, short_err_d;
   logic             frame_err_q, frame_err_d;
   logic             accept;
   logic             timed_out;

   // Next-state and registered-output logic for the nibble pairing FSM.
   always_comb begin
      state_d       = state_q;
      hi_nib_d      = hi_nib_q;
      lrs_d         = lrs_q;
      tmo_d         = tmo_q;
      byte_valid_d  = 1'b0;
      byte_data_d   = byte_data_q;
      byte_rs_d     = byte_rs_q;
      init_valid_d  = 1'b0;
      init_nibble_d = init_nibble_q;
      short_err_d   = q_short;
      frame_err_d   = 1'b0;

      // Read cycles are invisible: no outputs, no state, timeout keeps running.
      accept    = q_valid & ~q_rw;
      timed_out = (tmo_q == CNT_W'(NIBBLE_TIMEOUT));

      case (state_q)
         ST_SYNC8: begin
            if (accept) begin
               if (q_rs == RS_DATA) begin
                  frame_err_d = 1'b1;
               end else begin
                  init_valid_d  = 1'b1;
                  init_nibble_d = q_nib;
                  if (q_nib == LCD_INIT_4BIT) begin
                     state_d = ST_HI;
                  end
               end
            end
         end

         ST_HI: begin
            if (accept) begin
               hi_nib_d = q_nib;
               lrs_d    = q_rs;
               tmo_d    = '0;
               state_d  = ST_LO;
            end
         end

         ST_LO: begin
            tmo_d = tmo_q + 1'b1;
            // A fall arriving in the timeout cycle still completes the pair.
            if (accept) begin
               if (q_rs == lrs_q) begin
                  byte_valid_d = 1'b1;
                  byte_data_d  = {hi_nib_q, q_nib};
                  byte_rs_d    = lrs_q;
                  state_d      = ST_HI;
               end else begin
                  frame_err_d = 1'b1;
                  hi_nib_d    = q_nib;
                  lrs_d       = q_rs;
                  tmo_d       = '0;
               end
            end else if (timed_out) begin
               frame_err_d = 1'b1;
               state_d     = ST_HI;
            end
         end

         default: begin
            state_d = ST_SYNC8;
         end
      endcase

      synced_d = (state_d != ST_SYNC8);
   end

   // FSM state and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_SYNC8;
         hi_nib_q      <= '0;
         lrs_q         <= RS_CMD;
         tmo_q         <= '0;
         byte_valid_q  <= 1'b0;
         byte_data_q   <= '0;
         byte_rs_q     <= RS_CMD;
         init_valid_q  <= 1'b0;
         init_nibble_q <= '0;
         synced_q      <= 1'b0;
         short_err_q   <= 1'b0;
         frame_err_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         hi_nib_q      <= hi_nib_d;
         lrs_q         <= lrs_d;
         tmo_q         <= tmo_d;
         byte_valid_q  <= byte_valid_d;
         byte_data_q   <= byte_data_d;
         byte_rs_q     <= byte_rs_d;
         init_valid_q  <= init_valid_d;
         init_nibble_q <= init_nibble_d;
         synced_q      <= synced_d;
         short_err_q   <= short_err_d;
         frame_err_q   <= frame_err_d;
      end
   end

   assign byte_valid  = byte_valid_q;
   assign byte_data   = byte_data_q;
   assign byte_rs     = byte_rs_q;
   assign init_valid  = init_valid_q;
   assign init_nibble = init_nibble_q;
   assign synced      = synced_q;
   assign short_err   = short_err_q;
   assign frame_err   = frame_err_q;

endmodule
